// File: rtl/bit_serializer_pkg.sv
// Shared constants and helpers for the bit serializer.
package bit_serializer_pkg;

  // FSM encodings
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Level driven on sout when no word is being shifted
  localparam logic IDLE_LEVEL = 1'b0;

  // Widest word the serializer supports
  localparam int unsigned MAX_WIDTH = 32;

  // Bit that goes onto the line first, for a word of the given width.
  function automatic logic next_bit(
    input logic [MAX_WIDTH-1:0] word,
    input logic                 msb_first,
    input int unsigned          width
  );
    logic [4:0] pos;
    logic       b;
    pos = 5'(width - 1);
    if (msb_first) b = word[pos];
    else           b = word[0];
    return b;
  endfunction

endpackage

// File: rtl/bit_serializer_hold.sv
// One-entry holding register that buffers the next word while the shifter is busy.
module bit_serializer_hold #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             take,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] data,
  output logic             full
);

  // Capture on load, release on take; the two strobes are mutually exclusive
  // because a word is only offered while the entry is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      full <= 1'b0;
    end else if (take) begin
      full <= 1'b0;
    end else if (load) begin
      data <= din;
      full <= 1'b1;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word holding buffer for gapless streaming.
//
//  state    | meaning
//  ST_IDLE  | shifter empty, sout at idle level
//  ST_SHIFT | a word is on the line, count = bits left after the current one
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter logic        MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = IDLE_LEVEL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned   CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] load_word;
  logic [CW-1:0]    count_q, count_d;
  logic             sout_q, sout_d;
  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             accept;
  logic             at_last;
  logic             hold_load;
  logic             hold_take;
  logic             load_en;

  assign din_ready = !hold_full && !rst;
  assign accept    = din_valid && din_ready;
  assign at_last   = (state_q == ST_SHIFT) && (count_q == '0);
  assign hold_load = accept && (state_q == ST_SHIFT) && (count_q != '0);
  assign hold_take = at_last && hold_full;

  // The hold is always empty in IDLE, so a held word takes priority only at a word boundary.
  assign load_word = hold_full ? hold_data : din;
  assign load_en   = ((state_q == ST_IDLE) && accept) || (at_last && (hold_full || accept));
  assign shifted   = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

  bit_serializer_hold #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk  (clk),
    .rst  (rst),
    .load (hold_load),
    .take (hold_take),
    .din  (din),
    .data (hold_data),
    .full (hold_full)
  );

  // Next-state: load a fresh word, shift the current one, or fall back to idle.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    count_d = count_q;
    sout_d  = sout_q;
    if (load_en) begin
      state_d = ST_SHIFT;
      shreg_d = load_word;
      count_d = LAST_IDX;
      sout_d  = next_bit(MAX_WIDTH'(load_word), MSB_FIRST, WIDTH);
    end else if ((state_q == ST_SHIFT) && (count_q != '0)) begin
      shreg_d = shifted;
      count_d = count_q - CW'(1);
      sout_d  = next_bit(MAX_WIDTH'(shifted), MSB_FIRST, WIDTH);
    end else if (at_last) begin
      state_d = ST_IDLE;
      count_d = '0;
      sout_d  = IDLE_BIT;
    end
  end

  // State registers; reset drops any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      count_q <= '0;
      sout_q  <= IDLE_BIT;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      count_q <= count_d;
      sout_q  <= sout_d;
    end
  end

  assign sout       = sout_q;
  assign sout_valid = (state_q == ST_SHIFT);
  assign word_done  = at_last;
  assign busy       = (state_q == ST_SHIFT) || hold_full;

endmodule
